mover_ctrl: RTL and testbench
=============================

MOVER_CTRL -- requirements
Module: mover_ctrl

Interface
REQ-001 The block SHALL have parameter SPD_W, default 8, as the width of the speed divisor.
REQ-002 The block SHALL have parameter CNT_W, default 8, as the width of the bounce counter and bounce limit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to begin motion.
REQ-006 The block SHALL have port stop, input, 1 bit: abort motion and return to idle.
REQ-007 The block SHALL have port modo, input, 1 bit: 0 selects continuous bounce, 1 selects a single pass.
REQ-008 The block SHALL have port speed, input, SPD_W bits: step period minus one, in clk cycles.
REQ-009 The block SHALL have port lim, input, CNT_W bits: bounce limit in bounce mode, where 0 means unlimited.
REQ-010 The block SHALL have port x_min, input, 1 bit: position at or below the lower bound, from the position counter.
REQ-011 The block SHALL have port x_max, input, 1 bit: position at or above the upper bound, from the position counter.
REQ-012 The block SHALL have port oper, output, 2 bits: step command to the position counter (10 = +1, 01 = -1, 00 = hold; 11 is never driven).
REQ-013 The block SHALL have port busy, output, 1 bit: high in states UP and DOWN.
REQ-014 The block SHALL have port done, output, 1 bit: high in state DONE.
REQ-015 The block SHALL have port bounces, output, CNT_W bits: the number of direction reversals since the last accepted start.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, UP, DOWN and DONE.
REQ-017 In IDLE and DONE, an asserted start without stop SHALL cause the next state UP, clear bounces to 0 and clear the prescaler to 0.
REQ-018 In UP or DOWN, start SHALL be ignored.
REQ-019 An asserted stop SHALL force the next state to IDLE from any state, taking priority over start and over the limit flags; bounces SHALL hold its value.
REQ-020 Prescaler pc SHALL count from 0 to speed and then wrap to 0; the internal tick SHALL be high in the cycle where pc == speed, so a speed of 0 gives a tick every cycle.
REQ-021 oper SHALL be registered: it SHALL equal 10 for exactly the one cycle after a tick in UP, 01 for exactly the one cycle after a tick in DOWN, and 00 otherwise.
REQ-022 No step pulse SHALL be issued toward an asserted limit: no pulse in UP while x_max is 1, and no pulse in DOWN while x_min is 1.
REQ-023 In UP with x_max == 1: if modo == 1, the next state SHALL be DONE; if modo == 0, the next state SHALL be DOWN and bounces SHALL increment by 1.
REQ-024 In DOWN with x_min == 1: if modo == 1, the next state SHALL be DONE; if modo == 0, the next state SHALL be UP and bounces SHALL increment by 1.
REQ-025 If x_min and x_max are both 1, x_min SHALL take priority: the block SHALL move to UP (or DONE when modo == 1), and a bounce SHALL count only if the state was DOWN.
REQ-026 Each direction change SHALL clear pc to 0, and no oper pulse SHALL be issued in the cycle the state changes.
REQ-027 In bounce mode with lim != 0, the reversal that makes bounces equal to lim SHALL send the FSM to DONE instead of the new direction.
REQ-028 bounces SHALL saturate at 2^CNT_W - 1 and SHALL NOT wrap.
REQ-029 A change of speed while busy SHALL take effect at the next comparison; if pc > speed, pc SHALL wrap to 0 on the next cycle without a tick.
REQ-030 busy and done SHALL be decoded directly from the state register, with no extra latency.

Reset
REQ-031 While reset is high, the block SHALL hold state IDLE, pc = 0, oper = 00, bounces = 0, busy = 0 and done = 0, regardless of the other inputs.
REQ-032 A reset asserted mid-motion SHALL force oper to 00 immediately (asynchronously); the block SHALL then wait for a new start after release.
REQ-033 On the first edge after reset is released, start SHALL be honoured.

Verification
REQ-034 Step rate: reset, speed = 3, modo = 0, start pulse, limits low -> oper = 10 for one cycle every 4 cycles, with the first pulse 4 cycles after the start edge; busy = 1.
REQ-035 Bounce: running UP with lim = 0, x_max pulsed high -> next state DOWN, bounces = 1, no pulse in the turn cycle, then oper = 01 pulses.
REQ-036 Single pass: modo = 1, start, x_max raised -> done = 1, busy = 0, oper = 00 held; a new start clears bounces and restarts UP.
REQ-037 Limit: modo = 0, lim = 2, alternate x_max and x_min -> DONE on the second reversal with bounces = 2.
REQ-038 Priority: stop and start asserted together while busy -> IDLE; both limits high while in DOWN -> UP, with bounces incremented once.
REQ-039 Asynchronous reset: reset asserted in the cycle where oper = 10 -> oper = 00 before the next edge, with all outputs at their REQ-031 values.

Source files
------------

// File: rtl/mover_ctrl.sv
// Step-pulse sequencer for a position counter: runs up/down between limit flags,
// either bouncing (optionally up to a reversal limit) or making a single pass.
module mover_ctrl #(
   parameter int SPD_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             modo,
   input  logic [SPD_W-1:0] speed,
   input  logic [CNT_W-1:0] lim,
   input  logic             x_min,
   input  logic             x_max,
   output logic [1:0]       oper,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] bounces
);

   typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

   localparam logic [SPD_W-1:0] PC_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t           state_q, state_d;
   logic [SPD_W-1:0] pc_q, pc_d;
   logic [1:0]       oper_q, oper_d;
   logic [CNT_W-1:0] bounces_q, bounces_d;

   logic             tick;
   logic [CNT_W-1:0] bnc_inc;
   logic             lim_hit;

   assign tick    = (pc_q == speed);
   assign bnc_inc = (bounces_q == '1) ? bounces_q : bounces_q + CNT_ONE;
   assign lim_hit = (lim != '0) && (bnc_inc == lim);

   always_comb begin
      state_d   = state_q;
      // pc above a freshly lowered speed wraps without producing a tick
      pc_d      = (pc_q >= speed) ? '0 : pc_q + PC_ONE;
      oper_d    = 2'b00;
      bounces_d = bounces_q;
      case (state_q)
         IDLE, DONE: begin
            pc_d = '0;
            if (start) begin
               state_d   = UP;
               bounces_d = '0;
            end
         end
         UP: begin
            if (x_max) begin
               if (modo) begin
                  state_d = DONE;
               end else if (!x_min) begin
                  bounces_d = bnc_inc;
                  state_d   = lim_hit ? DONE : DOWN;
                  pc_d      = '0;
               end
            end else if (tick) begin
               oper_d = 2'b10;
            end
         end
         DOWN: begin
            if (x_min) begin
               if (modo) begin
                  state_d = DONE;
               end else begin
                  bounces_d = bnc_inc;
                  state_d   = lim_hit ? DONE : UP;
                  pc_d      = '0;
               end
            end else if (tick) begin
               oper_d = 2'b01;
            end
         end
         default: state_d = IDLE;
      endcase
      if (stop) begin
         state_d   = IDLE;
         pc_d      = '0;
         oper_d    = 2'b00;
         bounces_d = bounces_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         oper_q    <= 2'b00;
         bounces_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         oper_q    <= oper_d;
         bounces_q <= bounces_d;
      end
   end

   assign oper    = oper_q;
   assign bounces = bounces_q;
   assign busy    = (state_q == UP) || (state_q == DOWN);
   assign done    = (state_q == DONE);

endmodule

// File: tb/tb_mover_ctrl.sv
// Bench for mover_ctrl: expected step pulses go into a scoreboard queue and are
// popped by a negedge monitor; state outputs are checked directly by the stimulus.
module tb_mover_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, stop, modo;
   logic [7:0] speed;
   logic [7:0] lim;
   logic       x_min, x_max;
   logic [1:0] oper;
   logic       busy, done;
   logic [7:0] bounces;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      logic [1:0] op;
      int         at;
   } exp_t;
   exp_t sb[$];

   mover_ctrl #(.SPD_W(8), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .modo(modo),
      .speed(speed), .lim(lim), .x_min(x_min), .x_max(x_max),
      .oper(oper), .busy(busy), .done(done), .bounces(bounces)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [1:0] op, input int at);
      exp_t e;
      e.op = op;
      e.at = at;
      sb.push_back(e);
   endtask

   // Each input change happens 1 time unit after a rising edge.
   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (!reset && oper != 2'b00) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", int'(oper), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_oper", int'(oper), int'(e.op));
            chk("pulse_cycle", cyc, e.at);
         end
      end
   end

   initial begin
      int s, t, u, w, v;
      reset = 1'b1; start = 1'b1; stop = 1'b0; modo = 1'b0;
      speed = 8'd3; lim = 8'd0; x_min = 1'b0; x_max = 1'b0;

      // Reset holds idle even with start asserted
      repeat (3) @(posedge clk);
      #1;
      chk("rst_oper", int'(oper), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_bounces", int'(bounces), 0);
      reset = 1'b0;

      // First edge after release honours start; step every 4 cycles
      @(posedge clk);
      #1;
      s = cyc;
      start = 1'b0;
      chk("start_busy", int'(busy), 1);
      chk("start_bounces", int'(bounces), 0);
      push(2'b10, s + 4);
      push(2'b10, s + 8);

      // Bounce at x_max: turn with no pulse, then down pulses
      wait_cyc(s + 9);
      x_max = 1'b1;
      wait_cyc(s + 10);
      x_max = 1'b0;
      chk("turn_oper", int'(oper), 0);
      chk("turn_bounces", int'(bounces), 1);
      chk("turn_busy", int'(busy), 1);
      push(2'b01, s + 14);
      push(2'b01, s + 18);

      // Both limits in DOWN: back to UP, one bounce
      wait_cyc(s + 19);
      x_min = 1'b1; x_max = 1'b1;
      wait_cyc(s + 20);
      x_min = 1'b0; x_max = 1'b0;
      chk("both_bounces", int'(bounces), 2);
      chk("both_busy", int'(busy), 1);
      push(2'b10, s + 24);

      // stop beats start
      wait_cyc(s + 25);
      stop = 1'b1; start = 1'b1;
      wait_cyc(s + 26);
      stop = 1'b0; start = 1'b0;
      chk("stop_busy", int'(busy), 0);
      chk("stop_done", int'(done), 0);
      chk("stop_bounces", int'(bounces), 2);

      // Single pass at speed 0
      t = s + 28;
      wait_cyc(t);
      modo = 1'b1; speed = 8'd0; start = 1'b1;
      wait_cyc(t + 1);
      start = 1'b0;
      chk("pass_bounces", int'(bounces), 0);
      chk("pass_busy", int'(busy), 1);
      push(2'b10, t + 2);
      push(2'b10, t + 3);
      wait_cyc(t + 3);
      x_max = 1'b1;
      wait_cyc(t + 4);
      x_max = 1'b0;
      chk("pass_done", int'(done), 1);
      chk("pass_nbusy", int'(busy), 0);
      chk("pass_oper", int'(oper), 0);
      wait_cyc(t + 5);
      chk("done_oper_hold", int'(oper), 0);
      wait_cyc(t + 6);
      start = 1'b1;
      wait_cyc(t + 7);
      start = 1'b0; stop = 1'b1;
      chk("restart_busy", int'(busy), 1);
      chk("restart_done", int'(done), 0);
      wait_cyc(t + 8);
      stop = 1'b0;
      chk("stop2_busy", int'(busy), 0);

      // Reversal limit of 2
      u = t + 10;
      wait_cyc(u);
      modo = 1'b0; lim = 8'd2; speed = 8'd1; start = 1'b1;
      wait_cyc(u + 1);
      start = 1'b0;
      wait_cyc(u + 2);
      x_max = 1'b1;
      wait_cyc(u + 3);
      x_max = 1'b0; x_min = 1'b1;
      chk("lim_b1", int'(bounces), 1);
      chk("lim_busy1", int'(busy), 1);
      wait_cyc(u + 4);
      x_min = 1'b0;
      chk("lim_done", int'(done), 1);
      chk("lim_b2", int'(bounces), 2);
      chk("lim_nbusy", int'(busy), 0);

      // Saturation: reversal on every edge
      w = u + 6;
      wait_cyc(w);
      lim = 8'd0; speed = 8'd0; start = 1'b1;
      wait_cyc(w + 1);
      start = 1'b0; x_max = 1'b1; x_min = 1'b0;
      for (int i = 0; i < 260; i++) begin
         @(posedge clk);
         #1;
         x_max = ~x_max;
         x_min = ~x_min;
      end
      chk("sat_bounces", int'(bounces), 255);
      chk("sat_busy", int'(busy), 1);
      x_max = 1'b0; x_min = 1'b0; stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      chk("sat_stop_bounces", int'(bounces), 255);

      // Asynchronous reset during an up pulse
      v = cyc + 2;
      wait_cyc(v);
      speed = 8'd3; start = 1'b1;
      wait_cyc(v + 1);
      start = 1'b0;
      push(2'b10, v + 5);
      wait_cyc(v + 5);
      #5;
      reset = 1'b1;
      #1;
      chk("arst_oper", int'(oper), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_bounces", int'(bounces), 0);
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("arst_hold_busy", int'(busy), 0);
      reset = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("arst_wait_start", int'(busy), 0);
      chk("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
